// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver. Samples each bit at mid-bit using a
// bit-timing counter started from the synchronised falling edge of rx, and
// delivers each correctly framed byte with a single-cycle valid pulse.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | timing half a bit to re-check the start bit at its centre
// DATA  | sampling the 8 data bits (LSB first) at mid-bit
// STOP  | sampling the stop bit; reports the byte or a framing error
module uart_rx_byte #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       valid,
    output logic [7:0] data_out,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state, state_next;

    logic rx_m, rx_s, rx_d;
    logic [CNT_W-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;

    logic cnt_clr, cnt_inc, idx_clr, sample_bit, load_out, err_out;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection;
    // all reset high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        idx_clr    = 1'b0;
        sample_bit = 1'b0;
        load_out   = 1'b0;
        err_out    = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                // Requires a genuine high-to-low transition, so a line stuck
                // low after a framing error cannot retrigger.
                if (rx_d && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        idx_clr    = 1'b1;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_clr    = 1'b1;
                    sample_bit = 1'b1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop-bit leaves half a bit of
                // margin to catch a start edge that follows with no gap.
                if (cnt == BIT_M1) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                    if (rx_s) begin
                        load_out = 1'b1;
                    end else begin
                        err_out = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx   <= 3'd0;
            shreg <= 8'h00;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (idx_clr) begin
                idx <= 3'd0;
            end else if (sample_bit) begin
                idx <= idx + 3'd1;
            end
            if (sample_bit) begin
                shreg[idx] <= rx_s;
            end
        end
    end

    // Registered outputs; data_out only updates on a good frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            data_out  <= 8'h00;
        end else begin
            valid     <= load_out;
            frame_err <= err_out;
            if (load_out) begin
                data_out <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: drives 8N1 frames onto rx and compares every output pulse
// (cycle, kind, byte) against a frame-level timing model.
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int LAT      = 2 + CPB / 2 + 9 * CPB;

    typedef struct {
        int         cyc;
        logic       v;
        logic       e;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       valid;
    logic [7:0] data_out;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ev_t ev_q[$];
    ev_t exp_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .rx        (rx),
        .valid     (valid),
        .data_out  (data_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Edge number: count of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which an output pulse is visible.
    always @(negedge clk) begin
        if (valid || frame_err) begin
            ev_q.push_back('{cyc, valid, frame_err, data_out});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a frame whose start bit is first sampled at edge k yields one
    // pulse visible in the cycle after edge k+LAT.
    task automatic expect_frame(input int k, input logic [7:0] b, input logic ok);
        if (ok) begin
            exp_q.push_back('{k + LAT, 1'b1, 1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back('{k + LAT, 1'b0, 1'b1, last_good});
        end
    endtask

    // Called at a negedge; returns at the negedge after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int k);
        rx = 1'b0;
        k  = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic compare_events(input string tag);
        int n;
        repeat (4) @(negedge clk);
        check({tag, "_count"}, ev_q.size(), exp_q.size());
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d_cyc", tag, i), ev_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s_ev%0d_valid", tag, i), ev_q[i].v, exp_q[i].v);
            check($sformatf("%s_ev%0d_ferr", tag, i), ev_q[i].e, exp_q[i].e);
            check($sformatf("%s_ev%0d_data", tag, i), ev_q[i].d, exp_q[i].d);
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int k;
        logic [7:0] b;
        logic ok;
        logic prev_ok;

        // Reset values
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_data", data_out, 8'h00);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        compare_events("idle");
        check("idle_data", data_out, 8'h00);

        // Single byte
        send_frame(8'h35, 1'b1, k);
        expect_frame(k, 8'h35, 1'b1);
        compare_events("single");
        check("single_data", data_out, 8'h35);

        // Back-to-back with no idle gap
        send_frame(8'h41, 1'b1, k);
        expect_frame(k, 8'h41, 1'b1);
        send_frame(8'h46, 1'b1, k);
        expect_frame(k, 8'h46, 1'b1);
        repeat (4) @(negedge clk);
        if (ev_q.size() >= 2) begin
            check("b2b_gap", ev_q[1].cyc - ev_q[0].cyc, 100);
        end else begin
            check("b2b_pulses", ev_q.size(), 2);
        end
        compare_events("b2b");

        // Start glitch, then a good frame
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        compare_events("glitch");
        send_frame(8'h30, 1'b1, k);
        expect_frame(k, 8'h30, 1'b1);
        compare_events("after_glitch");
        check("after_glitch_data", data_out, 8'h30);

        // Framing error, then line held low
        send_frame(8'h39, 1'b0, k);
        expect_frame(k, 8'h39, 1'b0);
        repeat (60) @(negedge clk);
        compare_events("ferr");
        check("ferr_data_kept", data_out, 8'h30);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        compare_events("ferr_recover_idle");
        send_frame(8'h5A, 1'b1, k);
        expect_frame(k, 8'h5A, 1'b1);
        compare_events("ferr_recover");

        // Reset during data bit 4 of 0x7E
        b  = 8'h7E;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", valid, 1'b0);
        check("midrst_ferr", frame_err, 1'b0);
        check("midrst_data", data_out, 8'h00);
        last_good = 8'h00;
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h42, 1'b1, k);
        expect_frame(k, 8'h42, 1'b1);
        compare_events("after_midrst");
        check("after_midrst_data", data_out, 8'h42);

        // Randomised frames with random gaps and occasional stop errors
        prev_ok = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int gap;
            gap = $urandom_range(0, 12);
            if (!prev_ok && gap < 1) gap = 1;
            rx = 1'b1;
            repeat (gap) @(negedge clk);
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok, k);
            expect_frame(k, b, ok);
            prev_ok = ok;
        end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        compare_events("random");
        check("random_final_data", data_out, last_good);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
